// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_pkg                                                               |
// | Shared types and constants for the instruction-memory loader.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN0 = 3'd1,
      S_LEN1 = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } loader_state_t;

   // Length header is a little-endian 16-bit word count.
   localparam int LEN_BYTES = 2;
   localparam int XLEN      = 32;
   localparam int BYTES     = XLEN / 8;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader                                                          |
// | Assembles UART bytes into little-endian words and writes them to     |
// | instruction memory from address 0, holding the core in reset.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_loader
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] wa,
   output logic [DATA_WIDTH-1:0] wd,
   output logic                  busy,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err
);

   localparam int          c_bytes = DATA_WIDTH / 8;
   localparam int          c_idx_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
   localparam int unsigned c_depth = 32'd1 << ADDR_WIDTH;

   loader_state_t         r_state;
   logic [15:0]           r_len;
   logic [c_idx_w-1:0]    r_idx;
   logic [DATA_WIDTH-1:0] r_buf;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_cnt;

   logic [15:0]           w_len;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_last_byte;
   logic                  w_final;
   logic                  w_len_big;
   logic                  w_all_written;

   always_comb begin
      w_len                  = {rx_data, r_len[7:0]};
      w_word                 = r_buf;
      w_word[r_idx*8 +: 8]   = rx_data;
      w_last_byte            = (32'(r_idx) == 32'(c_bytes - 1));
      w_final                = ((32'(r_cnt) + 32'd1) == 32'(r_len));
      w_len_big              = (32'(w_len) > c_depth);
      w_all_written          = (32'(r_cnt) == 32'(r_len));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_idx    <= '0;
         r_buf    <= '0;
         r_addr   <= '0;
         r_cnt    <= '0;
         we       <= 1'b0;
         wa       <= '0;
         wd       <= '0;
         busy     <= 1'b0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state  <= S_LEN0;
                  r_idx    <= '0;
                  r_cnt    <= '0;
                  r_addr   <= '0;
                  r_buf    <= '0;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            S_LEN0: begin
               if (rx_valid) begin
                  r_len[7:0] <= rx_data;
                  r_state    <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (rx_valid) begin
                  r_len[15:8] <= rx_data;
                  if (w_len == 16'd0) begin
                     r_state  <= S_DONE;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else if (w_len_big) begin
                     r_state  <= S_ERR;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // r_cnt reaches len in the cycle the final write is presented.
               if (w_all_written) begin
                  r_state  <= S_DONE;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  done     <= 1'b1;
               end else if (rx_valid) begin
                  if (w_last_byte) begin
                     we    <= 1'b1;
                     wa    <= r_addr;
                     wd    <= w_word;
                     r_buf <= '0;
                     r_idx <= '0;
                     r_cnt <= r_cnt + 1'b1;
                     if (!w_final) begin
                        r_addr <= r_addr + 1'b1;
                     end
                  end else begin
                     r_buf <= w_word;
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader                                                       |
// | Directed vector table plus hand-written multi-cycle sequences.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        we;
   logic [9:0]  wa;
   logic [31:0] wd;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int n_vec = 0;
   int n_bad = 0;
   int n_we  = 0;

   typedef struct {
      logic        s;
      logic        v;
      logic [7:0]  d;
      logic        e_we;
      logic [9:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .busy     (busy),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (we === 1'b1) n_we++;

   function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                               input logic e_we, input logic [9:0] e_wa,
                               input logic [31:0] e_wd, input logic e_busy,
                               input logic e_done, input logic e_err);
      vec_t r;
      r.s = s; r.v = v; r.d = d;
      r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd;
      r.e_busy = e_busy; r.e_done = e_done; r.e_err = e_err;
      return r;
   endfunction

   task automatic step(input logic s, input logic v, input logic [7:0] d);
      start    = s;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_flags(input string nm, input logic e_we, input logic e_busy,
                            input logic e_done, input logic e_err);
      chk(nm, {59'd0, we, busy, cpu_hold, done, err},
              {59'd0, e_we, e_busy, e_busy, e_done, e_err});
   endtask

   initial begin
      int we0;
      logic [31:0] exp_word;

      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      chk("reset_values", {17'd0, we, wa, wd, busy, cpu_hold, done, err}, 64'd0);
      rst_n = 1'b1;

      // rx_valid in IDLE must not start anything
      we0 = n_we;
      step(0, 1, 8'h02);
      step(0, 1, 8'h00);
      step(0, 0, 8'h00);
      chk_flags("idle_rx_ignored", 0, 0, 0, 0);
      chk("idle_rx_no_write", 64'(n_we - we0), 64'd0);

      // Basic load, zero length, oversize, start ignored during DATA
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h02, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h13, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 1, 10'd0, 32'h0000_0013, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h93, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h10, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 1, 10'd1, 32'h0010_0093, 1, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 8'h55, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'hBB, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'hCC, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 8'hDD, 1, 10'd0, 32'hDDCC_BBAA, 1, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0));

      we0 = n_we;
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].s, tbl[i].v, tbl[i].d);
         chk_flags($sformatf("vec%0d_flags", i), tbl[i].e_we, tbl[i].e_busy,
                   tbl[i].e_done, tbl[i].e_err);
         if (tbl[i].e_we) begin
            chk($sformatf("vec%0d_wa", i), 64'(wa), 64'(tbl[i].e_wa));
            chk($sformatf("vec%0d_wd", i), 64'(wd), 64'(tbl[i].e_wd));
         end
      end
      chk("table_write_count", 64'(n_we - we0), 64'd3);
      chk("wd_holds_last", 64'(wd), 64'h0000_0000_DDCC_BBAA);

      // Reset in the middle of a word
      we0 = n_we;
      step(1, 0, 8'h00);
      step(0, 1, 8'h02);
      step(0, 1, 8'h00);
      step(0, 1, 8'h11);
      step(0, 1, 8'h22);
      rst_n = 1'b0;
      step(0, 0, 8'h00);
      rst_n = 1'b1;
      chk("midword_reset_values", {17'd0, we, wa, wd, busy, cpu_hold, done, err}, 64'd0);
      chk("midword_no_write", 64'(n_we - we0), 64'd0);
      step(1, 0, 8'h00);
      step(0, 1, 8'h01);
      step(0, 1, 8'h00);
      step(0, 1, 8'h44);
      step(0, 1, 8'h33);
      step(0, 1, 8'h22);
      step(0, 1, 8'h11);
      chk("reload_write", {21'd0, we, wa, wd}, {21'd0, 1'b1, 10'd0, 32'h1122_3344});
      step(0, 0, 8'h00);
      chk_flags("reload_done", 0, 0, 1, 0);

      // Full depth, one byte per cycle
      we0 = n_we;
      step(1, 0, 8'h00);
      step(0, 1, 8'h00);
      step(0, 1, 8'h04);
      chk_flags("full_len_accepted", 0, 1, 0, 0);
      for (int k = 0; k < 4096; k++) begin
         step(0, 1, 8'(k));
         if ((k % 4) == 3) begin
            exp_word = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
            chk($sformatf("full_w%0d", k / 4), {21'd0, we, wa, wd},
                {21'd0, 1'b1, 10'(k / 4), exp_word});
         end
      end
      step(0, 0, 8'h00);
      chk_flags("full_done", 0, 0, 1, 0);
      chk("full_final_wa", 64'(wa), 64'd1023);
      chk("full_write_count", 64'(n_we - we0), 64'd1024);
      step(0, 1, 8'h77);
      step(0, 0, 8'h00);
      chk_flags("done_sticky", 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
